// File: rtl/pz_sum_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : pz_sum_pipeline
//  Description : Pole/zero term accumulator. Sums the first no_z terms
//                (zeros) and the following no_p terms (poles) through a
//                registered adder tree and outputs zeros minus poles, with
//                valid/ready flow control, signed/unsigned terms,
//                saturate/wrap result handling and overflow/config flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module pz_sum_pipeline #(
    parameter int N_TERMS   = 8,
    parameter int DATA_SIZE = 8,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_SIZE*N_TERMS-1:0]   flat_pz,
    input  logic [$clog2(N_TERMS):0]       no_z,
    input  logic [$clog2(N_TERMS):0]       no_p,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_SIZE-1:0]           acc_pz,
    output logic                           acc_ovf,
    output logic                           cfg_err
);

    localparam int c_lvl   = $clog2(N_TERMS);
    localparam int c_cnt_w = c_lvl + 1;
    localparam int c_iw    = DATA_SIZE + c_lvl + 1;

    // Counts are handled one bit wider so sums of two counts cannot wrap.
    localparam logic [c_cnt_w:0] c_n    = (c_cnt_w + 1)'(N_TERMS);
    localparam bit               c_sext = (SIGNED != 0);

    // Representable output range, expressed at the internal width.
    localparam logic signed [c_iw-1:0] c_hi = c_sext ?
        {{(c_lvl + 2){1'b0}}, {(DATA_SIZE - 1){1'b1}}} :
        {{(c_lvl + 1){1'b0}}, {DATA_SIZE{1'b1}}};
    localparam logic signed [c_iw-1:0] c_lo = c_sext ?
        {{(c_lvl + 2){1'b1}}, {(DATA_SIZE - 1){1'b0}}} :
        {c_iw{1'b0}};

    logic                     w_adv;
    logic [c_cnt_w:0]         w_nz_e;
    logic [c_cnt_w:0]         w_np_e;
    logic [c_cnt_w:0]         w_ez;
    logic [c_cnt_w:0]         w_rem;
    logic [c_cnt_w:0]         w_ep;
    logic [c_cnt_w:0]         w_zp_end;
    logic                     w_cfg_err;

    logic signed [c_iw-1:0]   w_leaf_z [N_TERMS];
    logic signed [c_iw-1:0]   w_leaf_p [N_TERMS];

    // Adder tree stored heap-style: node 1 is the root, children of node n
    // are 2n and 2n+1; nodes N/2..N-1 add pairs of selected input terms.
    logic signed [c_iw-1:0]   w_zsum_d [1:N_TERMS-1];
    logic signed [c_iw-1:0]   w_psum_d [1:N_TERMS-1];
    logic signed [c_iw-1:0]   r_zsum   [1:N_TERMS-1];
    logic signed [c_iw-1:0]   r_psum   [1:N_TERMS-1];

    logic [c_lvl:1]           r_v;
    logic [c_lvl:1]           r_err;

    logic signed [c_iw-1:0]   w_diff;
    logic                     w_above;
    logic                     w_ovf;
    logic [DATA_SIZE-1:0]     w_res;

    logic                     r_out_valid;
    logic [DATA_SIZE-1:0]     r_acc_pz;
    logic                     r_acc_ovf;
    logic                     r_cfg_err;

    // Whole pipeline moves in lock-step whenever the output slot can drain.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Clamp the requested counts so zeros come first and poles fill the rest.
    always_comb begin
        w_nz_e    = {1'b0, no_z};
        w_np_e    = {1'b0, no_p};
        w_ez      = (w_nz_e > c_n) ? c_n : w_nz_e;
        w_rem     = c_n - w_ez;
        w_ep      = (w_np_e > w_rem) ? w_rem : w_np_e;
        w_zp_end  = w_ez + w_ep;
        w_cfg_err = (w_nz_e > c_n) || ((w_nz_e + w_np_e) > c_n);
    end

    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_term
        localparam logic [c_cnt_w:0] c_idx = (c_cnt_w + 1)'(gi);
        logic [DATA_SIZE-1:0]   w_raw;
        logic signed [c_iw-1:0] w_ext;

        assign w_raw         = flat_pz[DATA_SIZE*gi +: DATA_SIZE];
        assign w_ext         = {{(c_iw - DATA_SIZE){c_sext & w_raw[DATA_SIZE-1]}}, w_raw};
        assign w_leaf_z[gi]  = (c_idx < w_ez) ? w_ext : '0;
        assign w_leaf_p[gi]  = ((c_idx >= w_ez) && (c_idx < w_zp_end)) ? w_ext : '0;
    end

    for (genvar gn = 1; gn < N_TERMS; gn++) begin : g_node
        if (2 * gn >= N_TERMS) begin : g_leaf
            assign w_zsum_d[gn] = w_leaf_z[2*gn-N_TERMS] + w_leaf_z[2*gn-N_TERMS+1];
            assign w_psum_d[gn] = w_leaf_p[2*gn-N_TERMS] + w_leaf_p[2*gn-N_TERMS+1];
        end else begin : g_inner
            assign w_zsum_d[gn] = r_zsum[2*gn] + r_zsum[2*gn+1];
            assign w_psum_d[gn] = r_psum[2*gn] + r_psum[2*gn+1];
        end
    end

    // Final difference, range check and saturate/wrap selection.
    always_comb begin
        w_diff  = r_zsum[1] - r_psum[1];
        w_above = (w_diff > c_hi);
        w_ovf   = w_above || (w_diff < c_lo);
        w_res   = w_diff[DATA_SIZE-1:0];
        if ((SATURATE != 0) && w_ovf) begin
            w_res = w_above ? c_hi[DATA_SIZE-1:0] : c_lo[DATA_SIZE-1:0];
        end
    end

    // Adder-tree stages plus their valid/config-error tags; bubbles shift too.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zsum <= '{default: '0};
            r_psum <= '{default: '0};
            r_v    <= '0;
            r_err  <= '0;
        end else if (w_adv) begin
            r_zsum   <= w_zsum_d;
            r_psum   <= w_psum_d;
            r_v[1]   <= in_valid;
            r_err[1] <= w_cfg_err;
            for (int k = 2; k <= c_lvl; k++) begin
                r_v[k]   <= r_v[k-1];
                r_err[k] <= r_err[k-1];
            end
        end
    end

    // Output register; holds its contents while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_acc_pz    <= '0;
            r_acc_ovf   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_v[c_lvl];
            r_acc_pz    <= w_res;
            r_acc_ovf   <= w_ovf;
            r_cfg_err   <= r_err[c_lvl];
        end
    end

    assign out_valid = r_out_valid;
    assign acc_pz    = r_acc_pz;
    assign acc_ovf   = r_acc_ovf;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
